// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and sizes for the matmul result collector
package matmul_pkg;

  localparam int DATA_W     = 64;
  localparam int N_PER_LANE = 32;
  localparam int IDX_W      = $clog2(N_PER_LANE);

  typedef struct packed {
    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } result_t;

  localparam int RESULT_W = $bits(result_t);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } collector_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with flush; a push on full is taken when a pop shares the edge
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/matmul_result_collector.sv
// rtl/matmul_result_collector.sv - two-lane result capture, tagging and round-robin merge; STALL_CNT_EN adds stall_cycles
module matmul_result_collector
  import matmul_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     valid_in0,
  input  logic signed [DATA_W-1:0] din_R0,
  input  logic signed [DATA_W-1:0] din_I0,
  input  logic                     valid_in1,
  input  logic signed [DATA_W-1:0] din_R1,
  input  logic signed [DATA_W-1:0] din_I1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_lane,
  output logic [IDX_W-1:0]         out_index,
  output logic signed [DATA_W-1:0] out_R,
  output logic signed [DATA_W-1:0] out_I,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(N_PER_LANE);

  collector_state_t state;
  logic [IDX_W:0]   cnt0;
  logic [IDX_W:0]   cnt1;
  result_t          din0;
  result_t          din1;
  result_t          dout0;
  result_t          dout1;
  result_t          sel;
  logic             empty0;
  logic             empty1;
  logic             full0;
  logic             full1;
  logic             in_en;
  logic             push0;
  logic             push1;
  logic             pop0;
  logic             pop1;
  logic             load;
  logic             grant;
  logic             last_grant;
  logic             finish;

  // A start in COLLECT flushes, so nothing else may move at that edge.
  assign in_en = (state == COLLECT) && !start;
  assign push0 = in_en && valid_in0 && (cnt0 < CNT_MAX);
  assign push1 = in_en && valid_in1 && (cnt1 < CNT_MAX);

  assign din0 = '{idx: cnt0[IDX_W-1:0], re: din_R0, im: din_I0};
  assign din1 = '{idx: cnt1[IDX_W-1:0], re: din_R1, im: din_I1};

  assign load  = in_en && (!out_valid || out_ready) && !(empty0 && empty1);
  assign grant = (!empty0 && !empty1) ? !last_grant : empty0;
  assign pop0  = load && !grant;
  assign pop1  = load && grant;
  assign sel   = grant ? dout1 : dout0;

  assign finish = (state == COLLECT) && (cnt0 == CNT_MAX) && (cnt1 == CNT_MAX) &&
                  empty0 && empty1 && (!out_valid || out_ready);

  sync_fifo #(
    .WIDTH(RESULT_W),
    .DEPTH(DEPTH)
  ) u_fifo0 (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(start),
    .push (push0),
    .din  (din0),
    .pop  (pop0),
    .dout (dout0),
    .empty(empty0),
    .full (full0)
  );

  sync_fifo #(
    .WIDTH(RESULT_W),
    .DEPTH(DEPTH)
  ) u_fifo1 (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(start),
    .push (push1),
    .din  (din1),
    .pop  (pop1),
    .dout (dout1),
    .empty(empty1),
    .full (full1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt0       <= '0;
      cnt1       <= '0;
      last_grant <= 1'b1;
      out_valid  <= 1'b0;
      out_lane   <= 1'b0;
      out_index  <= '0;
      out_R      <= '0;
      out_I      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else if (start) begin
      state      <= COLLECT;
      cnt0       <= '0;
      cnt1       <= '0;
      last_grant <= 1'b1;
      out_valid  <= 1'b0;
      out_lane   <= 1'b0;
      out_index  <= '0;
      out_R      <= '0;
      out_I      <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else if (state == COLLECT) begin
      // A dropped sample still consumes its index so the gap shows downstream.
      if (push0) cnt0 <= cnt0 + (IDX_W+1)'(1);
      if (push1) cnt1 <= cnt1 + (IDX_W+1)'(1);
      if ((push0 && full0 && !pop0) || (push1 && full1 && !pop1)) overflow <= 1'b1;

      if (load) begin
        out_valid  <= 1'b1;
        out_lane   <= grant;
        out_index  <= sel.idx;
        out_R      <= sel.re;
        out_I      <= sel.im;
        last_grant <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (finish) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (start) begin
      stall_cycles <= '0;
    end else if ((state == COLLECT) && out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
